// File: rtl/range_pkg.sv
// Shared types and constants for the range scheduler: FSM state encoding,
// default datapath width and the shortest window the RangeFinder can accept.
package range_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    CAPTURE = 2'd2,
    REJECT  = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 16;
  localparam int MIN_WIN       = 2;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: searches last+1, last+2, ... with wrap-around
// and returns the first requesting index both one-hot and encoded.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic            any_o,
  output logic [IDW-1:0]  id_o,
  output logic [NREQ-1:0] gnt_o
);

  logic           found_s;
  logic [IDW-1:0] cand_s;

  // Rotating priority search starting just after the previous winner
  always_comb begin
    found_s = 1'b0;
    cand_s  = '0;
    id_o    = '0;
    gnt_o   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = IDW'((int'(last_i) + k) % NREQ);
      if (!found_s && req_i[cand_s]) begin
        found_s = 1'b1;
        id_o    = cand_s;
      end else begin
        found_s = found_s;
      end
    end
    if (found_s) begin
      gnt_o = NREQ'(1'b1) << id_o;
    end else begin
      gnt_o = '0;
    end
    any_o = found_s;
  end

endmodule

// File: rtl/range_scheduler.sv
// Time-shares one RangeFinder between NREQ requesters: round-robin pick,
// stream the window with go/finish framing, return the range tagged by ID.
module range_scheduler
  import range_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREQ  = 4,
  parameter int LENW  = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][LENW-1:0]  win_len,
  input  logic [NREQ-1:0][WIDTH-1:0] sample_in,
  output logic [NREQ-1:0]            grant,
  output logic [WIDTH-1:0]           rf_data_in,
  output logic                       rf_go,
  output logic                       rf_finish,
  input  logic [WIDTH-1:0]           rf_range,
  input  logic                       rf_error,
  output logic [WIDTH-1:0]           result,
  output logic [IDW-1:0]             result_id,
  output logic                       result_err,
  output logic                       result_valid
);

  state_e            state_q, state_d;
  logic [IDW-1:0]    id_q, id_d, last_q, last_d;
  logic [LENW-1:0]   len_q, len_d, cnt_q, cnt_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [IDW-1:0]    rid_q, rid_d;
  logic              err_q, err_d, valid_q, valid_d;

  logic              win_any_s;
  logic [IDW-1:0]    win_id_s;
  logic [NREQ-1:0]   win_gnt_s;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i  (req),
    .last_i (last_q),
    .any_o  (win_any_s),
    .id_o   (win_id_s),
    .gnt_o  (win_gnt_s)
  );

  // Next-state logic and the datapath-facing strobes decoded from state
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    result_d   = result_q;
    rid_d      = rid_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    grant      = '0;
    rf_data_in = '0;
    rf_go      = 1'b0;
    rf_finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_any_s) begin
          id_d   = win_id_s;
          len_d  = win_len[win_id_s];
          last_d = win_id_s;
          cnt_d  = '0;
          // Short windows would raise go and finish together at the RangeFinder
          if (win_len[win_id_s] < LENW'(MIN_WIN)) begin
            state_d = REJECT;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        grant      = NREQ'(1'b1) << id_q;
        rf_data_in = sample_in[id_q];
        rf_go      = (cnt_q == '0);
        rf_finish  = (cnt_q == len_q - LENW'(1'b1));
        cnt_d      = cnt_q + LENW'(1'b1);
        if (rf_finish) begin
          state_d = CAPTURE;
        end else begin
          state_d = RUN;
        end
      end
      CAPTURE: begin
        result_d = rf_range;
        err_d    = rf_error;
        rid_d    = id_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      REJECT: begin
        result_d = '0;
        err_d    = 1'b1;
        rid_d    = id_q;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer and registered result group
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      id_q     <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      last_q   <= IDW'(NREQ - 1);
      result_q <= '0;
      rid_q    <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      result_q <= result_d;
      rid_q    <= rid_d;
      err_q    <= err_d;
      valid_q  <= valid_d;
    end
  end

  assign result       = result_q;
  assign result_id    = rid_q;
  assign result_err   = err_q;
  assign result_valid = valid_q;

  logic unused_s;
  assign unused_s = ^win_gnt_s;

endmodule

// File: tb/tb_range_scheduler.sv
// Directed bench for range_scheduler with a behavioural unsigned max-min
// RangeFinder model; table vectors plus hand-written multi-cycle sequences.
module tb_range_scheduler;

  logic             clock;
  logic             reset;
  logic [3:0]       req;
  logic [3:0][7:0]  win_len;
  logic [3:0][15:0] sample_in;
  logic [3:0]       grant;
  logic [15:0]      rf_data_in;
  logic             rf_go, rf_finish;
  logic [15:0]      rf_range;
  logic             rf_error;
  logic [15:0]      result;
  logic [1:0]       result_id;
  logic             result_err, result_valid;

  int n_checks = 0;
  int n_fail   = 0;

  range_scheduler #(.WIDTH(16), .NREQ(4), .LENW(8)) dut (
    .clock(clock), .reset(reset), .req(req), .win_len(win_len),
    .sample_in(sample_in), .grant(grant), .rf_data_in(rf_data_in),
    .rf_go(rf_go), .rf_finish(rf_finish), .rf_range(rf_range),
    .rf_error(rf_error), .result(result), .result_id(result_id),
    .result_err(result_err), .result_valid(result_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RangeFinder model: tracks unsigned max/min between go and finish
  logic [15:0] mx_q, mn_q, rng_q, nmax_s, nmin_s;
  logic        act_q, ferr_q, force_err;
  assign nmax_s = rf_go ? rf_data_in : ((rf_data_in > mx_q) ? rf_data_in : mx_q);
  assign nmin_s = rf_go ? rf_data_in : ((rf_data_in < mn_q) ? rf_data_in : mn_q);
  always @(posedge clock) begin
    if (reset) begin
      act_q <= 1'b0; rng_q <= 16'h0; ferr_q <= 1'b0; mx_q <= 16'h0; mn_q <= 16'h0;
    end else begin
      if (rf_go || act_q) begin mx_q <= nmax_s; mn_q <= nmin_s; end
      if (rf_finish) begin
        act_q  <= 1'b0;
        rng_q  <= nmax_s - nmin_s;
        ferr_q <= rf_go | ~(act_q | rf_go);
      end else if (rf_go) begin
        act_q <= 1'b1;
      end
    end
  end
  assign rf_range = rng_q;
  assign rf_error = ferr_q | force_err;

  typedef struct {
    logic [3:0]  req;
    logic [7:0]  len;
    logic [15:0] smp [5];
    logic [1:0]  exp_id;
    logic [15:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 4'b0; force_err = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  g;
    bit  seen;
    int  explen;
    g = 0; seen = 1'b0;
    explen = (v.len < 8'd2) ? 0 : int'(v.len);
    win_len = {4{v.len}};
    req = v.req;
    for (int cyc = 1; cyc <= 60 && !seen; cyc++) begin
      @(negedge clock);
      if (grant != 4'b0) begin
        check("grant_onehot", 32'(grant), 32'(4'b0001 << v.exp_id));
        check("rf_go", 32'(rf_go), 32'(g == 0));
        check("rf_finish", 32'(rf_finish), 32'(g == explen - 1));
        if (g < 5) sample_in = {4{v.smp[g]}};
        g++;
      end else begin
        check("rf_quiet", 32'({rf_go, rf_finish}), 32'd0);
      end
      if (result_valid) begin
        check("latency", 32'(cyc), 32'(v.exp_lat));
        check("result_id", 32'(result_id), 32'(v.exp_id));
        check("result", 32'(result), 32'(v.exp_res));
        check("result_err", 32'(result_err), 32'(v.exp_err));
        seen = 1'b1;
        req = 4'b0;
      end
    end
    if (!seen) check("result_timeout", 32'd0, 32'd1);
    check("grant_count", 32'(g), 32'(explen));
  endtask

  initial begin
    int exp_order [5];
    int gi, ri, g;
    bit seen, fin_seen;
    exp_order = '{0, 1, 2, 3, 0};

    // req, len, samples, id, result, err, latency
    vecs[0] = '{4'b0001, 8'd4, '{16'h7FFF, 16'h8000, 16'h8001, 16'h7FFE, 16'h0}, 2'd0, 16'h0003, 1'b0, 6};
    vecs[1] = '{4'b0100, 8'd1, '{16'h1111, 16'h0, 16'h0, 16'h0, 16'h0}, 2'd2, 16'h0000, 1'b1, 2};
    vecs[2] = '{4'b0100, 8'd0, '{16'h1111, 16'h0, 16'h0, 16'h0, 16'h0}, 2'd2, 16'h0000, 1'b1, 2};
    vecs[3] = '{4'b0010, 8'd3, '{16'h0100, 16'h0000, 16'hFFFF, 16'h0, 16'h0}, 2'd1, 16'hFFFF, 1'b0, 5};
    vecs[4] = '{4'b1000, 8'd2, '{16'h1234, 16'h1200, 16'h0, 16'h0, 16'h0}, 2'd3, 16'h0034, 1'b0, 4};
    vecs[5] = '{4'b0110, 8'd2, '{16'h0005, 16'h0009, 16'h0, 16'h0, 16'h0}, 2'd1, 16'h0004, 1'b0, 4};
    vecs[6] = '{4'b0110, 8'd2, '{16'h0010, 16'h0001, 16'h0, 16'h0, 16'h0}, 2'd2, 16'h000F, 1'b0, 4};
    vecs[7] = '{4'b0101, 8'd5, '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005}, 2'd0, 16'h0004, 1'b0, 7};

    req = 4'b0; win_len = '0; sample_in = '0; force_err = 1'b0; reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_rf", 32'({rf_go, rf_finish}), 32'd0);
    check("rst_result", 32'({result, result_id, result_err, result_valid}), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Round-robin fairness with every requester pending
    do_reset();
    win_len = {4{8'd2}}; sample_in = {4{16'h0042}}; req = 4'hF;
    gi = 0; ri = 0;
    for (int cyc = 0; cyc < 40 && gi < 5; cyc++) begin
      @(negedge clock);
      if (result_valid) begin
        check("rr_result_id", 32'(result_id), 32'(ri % 4));
        ri++;
      end
      if (rf_go) begin
        check("rr_order", 32'(grant), 32'(4'b0001 << exp_order[gi]));
        gi++;
      end
    end
    check("rr_grants", 32'(gi), 32'd5);
    check("rr_results", 32'(ri), 32'd4);
    req = 4'b0;
    repeat (6) @(negedge clock);

    // Error passthrough: RangeFinder flags error during CAPTURE
    win_len = {4{8'd2}}; req = 4'b0001; g = 0; seen = 1'b0; fin_seen = 1'b0;
    for (int cyc = 1; cyc <= 20 && !seen; cyc++) begin
      @(negedge clock);
      if (fin_seen) begin force_err = 1'b1; fin_seen = 1'b0; end
      if (grant != 4'b0) begin
        sample_in = (g == 0) ? {4{16'h0010}} : {4{16'h0030}};
        if (rf_finish) fin_seen = 1'b1;
        g++;
      end
      if (result_valid) begin
        check("err_result_err", 32'(result_err), 32'd1);
        check("err_result", 32'(result), 32'h0020);
        seen = 1'b1; req = 4'b0; force_err = 1'b0;
      end
    end
    if (!seen) check("err_timeout", 32'd0, 32'd1);
    force_err = 1'b0;

    // Reset mid-burst abandons it and reloads the round-robin pointer
    win_len = {4{8'd8}}; sample_in = {4{16'h0077}}; req = 4'b0100; g = 0;
    for (int cyc = 0; cyc < 20 && g < 4; cyc++) begin
      @(negedge clock);
      if (grant != 4'b0) g++;
    end
    check("mid_grants", 32'(g), 32'd4);
    reset = 1'b1; req = 4'b0;
    @(negedge clock);
    check("mid_grant", 32'(grant), 32'd0);
    check("mid_rf", 32'({rf_go, rf_finish}), 32'd0);
    check("mid_valid", 32'(result_valid), 32'd0);
    reset = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (result_valid) seen = 1'b1;
    end
    check("mid_no_result", 32'(seen), 32'd0);
    win_len = {4{8'd2}}; req = 4'b1010;
    @(negedge clock);
    check("post_rst_grant", 32'(grant), 32'b0010);
    seen = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clock);
      if (result_valid) begin
        check("post_rst_id", 32'(result_id), 32'd1);
        seen = 1'b1; req = 4'b0;
      end
    end
    if (!seen) check("post_rst_timeout", 32'd0, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
